ex_mem_pipe: RTL and testbench

//  Parametrised EX->MEM pipeline stage with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/ex_mem_pipe_pkg.sv | 36 +++
 rtl/ex_mem_pipe_skid_buf.sv | 94 +++++++++
 rtl/ex_mem_pipe.sv | 83 ++++++++
 tb/tb_ex_mem_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pipe_pkg.sv
// Shared types and constants for the EX->MEM pipeline stage.
// Default field widths, the NOP ex_code and the skid-buffer state encoding.
package ex_mem_pipe_pkg;

    localparam int REG_W_DEF  = 32;
    localparam int REG_AW_DEF = 5;
    localparam int MEM_W_DEF  = 32;
    localparam int MEM_AW_DEF = 32;
    localparam int OPC_W_DEF  = 7;
    localparam int EXC_W_DEF  = 8;

    localparam logic [EXC_W_DEF-1:0] EXC_NOP = 8'h00;

    typedef struct packed {
        logic [MEM_W_DEF-1:0]  mem_wdata;
        logic [MEM_AW_DEF-1:0] mem_raddr;
        logic [MEM_AW_DEF-1:0] mem_waddr;
        logic [REG_W_DEF-1:0]  reg_wdata;
        logic                  reg_we;
        logic [REG_AW_DEF-1:0] reg_waddr;
        logic [OPC_W_DEF-1:0]  opcode;
        logic [EXC_W_DEF-1:0]  ex_code;
    } ex_mem_pkt_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic int pkt_width(input int reg_w, input int reg_aw, input int mem_w,
                                     input int mem_aw, input int opc_w, input int exc_w);
        return mem_w + 2 * mem_aw + reg_w + 1 + reg_aw + opc_w + exc_w;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_buf.sv
// Generic 2-entry skid buffer with flush. With SKID=0 it degrades to a single
// entry whose ready is combinational from out_ready_i.
module pipe_skid_buf
    import ex_mem_pipe_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_q, rdy_d;
    logic         accept_s;
    logic         retire_s;

    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = head_q;
    // Registered ready keeps MEM back-pressure off the EX timing path.
    assign in_ready_o  = SKID ? rdy_q : (!out_valid_o || out_ready_i);
    assign accept_s    = in_valid_i && in_ready_o && !flush_i;
    assign retire_s    = out_valid_o && out_ready_i && !flush_i;

    // Next-state and payload steering.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept_s) begin
                        state_d = SKID_ONE;
                        head_d  = in_data_i;
                    end else begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (accept_s && retire_s) begin
                        head_d = in_data_i;
                    end else if (accept_s) begin
                        state_d = SKID_FULL;
                        skid_d  = in_data_i;
                    end else if (retire_s) begin
                        state_d = SKID_EMPTY;
                    end else begin
                        state_d = SKID_ONE;
                    end
                end
                SKID_FULL: begin
                    if (retire_s) begin
                        state_d = SKID_ONE;
                        head_d  = skid_q;
                    end else begin
                        state_d = SKID_FULL;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                end
            endcase
        end
        rdy_d = (state_d != SKID_FULL);
    end

    // State and payload registers; payload survives a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage: packs memory/writeback fields into a skid buffer
// and provides forwarding taps from the EX input and the MEM-side head.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int MEM_W  = MEM_W_DEF,
    parameter int MEM_AW = MEM_AW_DEF,
    parameter int OPC_W  = OPC_W_DEF,
    parameter int EXC_W  = EXC_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [MEM_W-1:0]  in_mem_wdata_i,
    input  logic [MEM_AW-1:0] in_mem_raddr_i,
    input  logic [MEM_AW-1:0] in_mem_waddr_i,
    input  logic [REG_W-1:0]  in_reg_wdata_i,
    input  logic              in_reg_we_i,
    input  logic [REG_AW-1:0] in_reg_waddr_i,
    input  logic [OPC_W-1:0]  in_opcode_i,
    input  logic [EXC_W-1:0]  in_ex_code_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [MEM_W-1:0]  out_mem_wdata_o,
    output logic [MEM_AW-1:0] out_mem_raddr_o,
    output logic [MEM_AW-1:0] out_mem_waddr_o,
    output logic [REG_W-1:0]  out_reg_wdata_o,
    output logic              out_reg_we_o,
    output logic [REG_AW-1:0] out_reg_waddr_o,
    output logic [OPC_W-1:0]  out_opcode_o,
    output logic [EXC_W-1:0]  out_ex_code_o,
    output logic              fwd_ex_we_o,
    output logic [REG_AW-1:0] fwd_ex_addr_o,
    output logic [REG_W-1:0]  fwd_ex_data_o,
    output logic              fwd_mem_we_o,
    output logic [REG_AW-1:0] fwd_mem_addr_o,
    output logic [REG_W-1:0]  fwd_mem_data_o
);

    localparam int PKT_W = pkt_width(REG_W, REG_AW, MEM_W, MEM_AW, OPC_W, EXC_W);

    logic [PKT_W-1:0] in_pkt_s;
    logic [PKT_W-1:0] head_pkt_s;
    logic             head_we_s;

    assign in_pkt_s = {in_mem_wdata_i, in_mem_raddr_i, in_mem_waddr_i, in_reg_wdata_i,
                       in_reg_we_i, in_reg_waddr_i, in_opcode_i, in_ex_code_i};

    pipe_skid_buf #(
        .W    (PKT_W),
        .SKID (SKID)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_pkt_s),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (head_pkt_s)
    );

    assign {out_mem_wdata_o, out_mem_raddr_o, out_mem_waddr_o, out_reg_wdata_o,
            head_we_s, out_reg_waddr_o, out_opcode_o, out_ex_code_o} = head_pkt_s;

    // A stale head left behind by a flush must never look like a write.
    assign out_reg_we_o   = head_we_s && out_valid_o;

    assign fwd_ex_we_o    = in_reg_we_i && in_valid_i && !flush_i;
    assign fwd_ex_addr_o  = in_reg_waddr_i;
    assign fwd_ex_data_o  = in_reg_wdata_i;

    assign fwd_mem_we_o   = out_reg_we_o;
    assign fwd_mem_addr_o = out_reg_waddr_o;
    assign fwd_mem_data_o = out_reg_wdata_o;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench: a SKID=1 and a SKID=0 instance run side by side against
// a queue-based reference model of the stage.
module tb_ex_mem_pipe;

    typedef struct packed {
        logic [31:0] mem_wdata;
        logic [31:0] mem_raddr;
        logic [31:0] mem_waddr;
        logic [31:0] reg_wdata;
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic [6:0]  opcode;
        logic [7:0]  ex_code;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n;
    pkt_t cur;
    logic in_valid [2];
    logic out_rdy  [2];
    logic flush    [2];

    logic        in_ready   [2];
    logic        out_valid  [2];
    logic [31:0] o_mem_wdata[2];
    logic [31:0] o_mem_raddr[2];
    logic [31:0] o_mem_waddr[2];
    logic [31:0] o_reg_wdata[2];
    logic        o_reg_we   [2];
    logic [4:0]  o_reg_waddr[2];
    logic [6:0]  o_opcode   [2];
    logic [7:0]  o_ex_code  [2];
    logic        fex_we     [2];
    logic [4:0]  fex_addr   [2];
    logic [31:0] fex_data   [2];
    logic        fmem_we    [2];
    logic [4:0]  fmem_addr  [2];
    logic [31:0] fmem_data  [2];
    pkt_t        obs_pkt    [2];

    pkt_t q0[$];
    pkt_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ex_mem_pipe #(.SKID(g == 1)) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .flush_i         (flush[g]),
            .in_valid_i      (in_valid[g]),
            .in_ready_o      (in_ready[g]),
            .in_mem_wdata_i  (cur.mem_wdata),
            .in_mem_raddr_i  (cur.mem_raddr),
            .in_mem_waddr_i  (cur.mem_waddr),
            .in_reg_wdata_i  (cur.reg_wdata),
            .in_reg_we_i     (cur.reg_we),
            .in_reg_waddr_i  (cur.reg_waddr),
            .in_opcode_i     (cur.opcode),
            .in_ex_code_i    (cur.ex_code),
            .out_valid_o     (out_valid[g]),
            .out_ready_i     (out_rdy[g]),
            .out_mem_wdata_o (o_mem_wdata[g]),
            .out_mem_raddr_o (o_mem_raddr[g]),
            .out_mem_waddr_o (o_mem_waddr[g]),
            .out_reg_wdata_o (o_reg_wdata[g]),
            .out_reg_we_o    (o_reg_we[g]),
            .out_reg_waddr_o (o_reg_waddr[g]),
            .out_opcode_o    (o_opcode[g]),
            .out_ex_code_o   (o_ex_code[g]),
            .fwd_ex_we_o     (fex_we[g]),
            .fwd_ex_addr_o   (fex_addr[g]),
            .fwd_ex_data_o   (fex_data[g]),
            .fwd_mem_we_o    (fmem_we[g]),
            .fwd_mem_addr_o  (fmem_addr[g]),
            .fwd_mem_data_o  (fmem_data[g])
        );
        // The raw head we is masked by out_valid, so rebuild it for payload comparison.
        assign obs_pkt[g] = {o_mem_wdata[g], o_mem_raddr[g], o_mem_waddr[g], o_reg_wdata[g],
                             o_reg_we[g], o_reg_waddr[g], o_opcode[g], o_ex_code[g]};
    end

    task automatic chk(input string tag, input int k, input logic [159:0] obs,
                       input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic set_pkt(input logic [31:0] wdata);
        logic [31:0] r;
        cur.mem_wdata = $urandom;
        cur.mem_raddr = $urandom;
        cur.mem_waddr = $urandom;
        cur.reg_wdata = wdata;
        r = $urandom;
        cur.reg_we    = r[0];
        cur.reg_waddr = r[5:1];
        cur.opcode    = r[12:6];
        cur.ex_code   = r[20:13];
    endtask

    task automatic set_all(input logic v, input logic rdy, input logic fl);
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = v;
            out_rdy[k]  = rdy;
            flush[k]    = fl;
        end
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic tick();
        bit   acc [2];
        bit   ret [2];
        int   sz;
        bit   rdy_m;
        pkt_t hd;
        #1;
        for (int k = 0; k < 2; k++) begin
            hd = '0;
            sz = (k == 0) ? q0.size() : q1.size();
            if (sz > 0) hd = (k == 0) ? q0[0] : q1[0];
            rdy_m = (k == 1) ? (sz < 2) : (sz == 0 || out_rdy[k]);
            chk("in_ready",   k, in_ready[k],  rdy_m);
            chk("out_valid",  k, out_valid[k], sz > 0);
            chk("out_reg_we", k, o_reg_we[k],  sz > 0 && hd.reg_we);
            chk("fwd_mem_we", k, fmem_we[k],   sz > 0 && hd.reg_we);
            chk("fwd_ex_we",  k, fex_we[k],    in_valid[k] && cur.reg_we && !flush[k]);
            chk("fwd_ex_fld", k, {fex_addr[k], fex_data[k]}, {cur.reg_waddr, cur.reg_wdata});
            if (sz > 0) begin
                chk("payload",     k, obs_pkt[k] & ~(160'd1 << 20), hd & ~(149'd1 << 20));
                chk("fwd_mem_fld", k, {fmem_addr[k], fmem_data[k]}, {hd.reg_waddr, hd.reg_wdata});
            end
            acc[k] = rst_n && in_valid[k] && rdy_m && !flush[k];
            ret[k] = rst_n && (sz > 0) && out_rdy[k] && !flush[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || flush[k]) begin
                if (k == 0) q0.delete(); else q1.delete();
            end else if (k == 0) begin
                if (ret[k]) void'(q0.pop_front());
                if (acc[k]) q0.push_back(cur);
            end else begin
                if (ret[k]) void'(q1.pop_front());
                if (acc[k]) q1.push_back(cur);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        cur   = '0;
        rst_n = 1'b0;
        set_all(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_all(1'b0, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, out_valid[k], 1'b0);
            chk("rst_reg_we",    k, o_reg_we[k],  1'b0);
            chk("rst_ex_code",   k, o_ex_code[k], 8'h00);
            chk("rst_in_ready",  k, in_ready[k],  1'b1);
        end

        // Streaming, 8 back-to-back packets.
        set_all(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            set_pkt(32'h10 + 32'(i));
            tick();
        end
        set_all(1'b0, 1'b1, 1'b0);
        repeat (2) tick();

        // Back-pressure with A then B.
        set_all(1'b1, 1'b0, 1'b0);
        set_pkt(32'hA); tick();
        set_pkt(32'hB); tick();
        set_all(1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", 1, in_ready[1],    1'b0);
        chk("bp_hold_a",   1, o_reg_wdata[1], 32'hA);
        tick();
        chk("bp_still_a",  1, o_reg_wdata[1], 32'hA);
        set_all(1'b0, 1'b1, 1'b0);
        tick();
        chk("bp_then_b",   1, o_reg_wdata[1], 32'hB);
        chk("bp_ready_up", 1, in_ready[1],    1'b1);
        tick();

        // Flush while FULL, with C presented in the flush cycle.
        set_all(1'b1, 1'b0, 1'b0);
        set_pkt(32'hA); tick();
        set_pkt(32'hB); tick();
        set_pkt(32'hC);
        set_all(1'b1, 1'b1, 1'b1);
        tick();
        set_all(1'b0, 1'b1, 1'b0);
        chk("fl_out_valid", 1, out_valid[1], 1'b0);
        chk("fl_fwd_mem",   1, fmem_we[1],   1'b0);
        tick();

        // Forwarding taps.
        cur = '0;
        cur.reg_we    = 1'b1;
        cur.reg_waddr = 5'd5;
        cur.reg_wdata = 32'h55;
        set_all(1'b1, 1'b1, 1'b0);
        #1;
        chk("fwd_ex", 1, {fex_we[1], fex_addr[1], fex_data[1]}, {1'b1, 5'd5, 32'h55});
        tick();
        chk("fwd_mem", 1, {fmem_we[1], fmem_addr[1], fmem_data[1]}, {1'b1, 5'd5, 32'h55});
        set_all(1'b0, 1'b1, 1'b0);
        tick();

        // out_ready toggling each cycle under continuous input.
        for (int i = 0; i < 16; i++) begin
            set_pkt($urandom);
            set_all(1'b1, 1'(i % 2), 1'b0);
            tick();
        end

        // Randomised traffic with occasional flush and mid-run reset.
        for (int i = 0; i < 400; i++) begin
            set_pkt($urandom);
            for (int k = 0; k < 2; k++) begin
                r = $urandom;
                in_valid[k] = r[0] | r[1];
                out_rdy[k]  = r[2] | r[3];
                flush[k]    = (r[7:4] == 4'd0);
            end
            r = $urandom;
            rst_n = (r[6:0] != 7'd0);
            tick();
        end
        rst_n = 1'b1;
        set_all(1'b0, 1'b1, 1'b0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
